ram_fifo_ctrl: RTL and testbench

- Synchronous FIFO controller that sits directly upstream of the 16x8 dual_port_ram.
- Turns a push/pop stream interface into the RAM's port-0 write and port-1 read signals.
- Tracks read/write pointers, occupancy, full/empty and error flags.
- Returns read data from the RAM with a valid strobe.

---
 rtl/ram_fifo_ctrl.sv | 118 +++++++++++
 tb/tb_ram_fifo_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: push/pop FIFO controller in front of a 16x8 dual-port RAM.
// Port 0 of the RAM is used for writes, port 1 for registered reads.
// Optional almost_full/almost_empty outputs: define RAM_FIFO_ALMOST_FLAGS_EN.
`timescale 1ns/1ps
module ram_fifo_ctrl #(
   parameter int DATA_WIDTH      = 8,
   parameter int ADDR_WIDTH      = 4,
   parameter int ALMOST_FULL_TH  = 14,
   parameter int ALMOST_EMPTY_TH = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] pop_data,
   output logic                  pop_valid,
   output logic                  full,
   output logic                  empty,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  overflow,
   output logic                  underflow,
   input  logic                  err_clr,
`ifdef RAM_FIFO_ALMOST_FLAGS_EN
   output logic                  almost_full,
   output logic                  almost_empty,
`endif
   output logic                  ram_wr_en,
   output logic                  ram_port_en_0,
   output logic [ADDR_WIDTH-1:0] ram_addr_0,
   output logic [DATA_WIDTH-1:0] ram_data_in,
   output logic                  ram_port_en_1,
   output logic [ADDR_WIDTH-1:0] ram_addr_1,
   input  logic [DATA_WIDTH-1:0] ram_data_out_1
);

   localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);

   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [ADDR_WIDTH:0]   count_q;
   logic                  vld_p1;
   logic                  ovf_q;
   logic                  udf_q;
   logic                  push_acc;
   logic                  pop_acc;
   logic                  ovf_set;
   logic                  udf_set;

   assign full  = (count_q == DEPTH_CNT);
   assign empty = (count_q == '0);
   assign count = count_q;

   // Accept/reject decisions; enables are held low while reset is asserted
   always_comb begin
      push_acc = push & ~full  & ~flush & ~rst;
      pop_acc  = pop  & ~empty & ~flush & ~rst;
      ovf_set  = push &  full  & ~flush;
      udf_set  = pop  &  empty & ~flush;
   end

   assign ram_wr_en     = push_acc;
   assign ram_port_en_0 = push_acc;
   assign ram_addr_0    = wr_ptr;
   assign ram_data_in   = push_data;
   assign ram_port_en_1 = pop_acc;
   assign ram_addr_1    = rd_ptr;

   // RAM read data arrives one cycle after the accepted pop
   assign pop_data  = ram_data_out_1;
   assign pop_valid = vld_p1;
   assign overflow  = ovf_q;
   assign underflow = udf_q;

`ifdef RAM_FIFO_ALMOST_FLAGS_EN
   assign almost_full  = (count_q >= (ADDR_WIDTH+1)'(ALMOST_FULL_TH));
   assign almost_empty = (count_q <= (ADDR_WIDTH+1)'(ALMOST_EMPTY_TH));
`endif

   // Pointers, occupancy and read-valid pipeline; flush clears them all
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
         vld_p1  <= 1'b0;
      end else if (flush) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
         vld_p1  <= 1'b0;
      end else begin
         vld_p1 <= pop_acc;
         if (push_acc) wr_ptr <= wr_ptr + 1'b1;
         if (pop_acc)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_acc, pop_acc})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Sticky error flags; a new rejection wins over a simultaneous clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         if (ovf_set)      ovf_q <= 1'b1;
         else if (err_clr) ovf_q <= 1'b0;
         if (udf_set)      udf_q <= 1'b1;
         else if (err_clr) udf_q <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Testbench for ram_fifo_ctrl: directed scenarios plus random traffic,
// checked against a queue-based FIFO model and a behavioural 16x8 RAM.
`timescale 1ns/1ps
module tb_ram_fifo_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       flush = 1'b0;
   logic       push = 1'b0;
   logic [7:0] push_data = '0;
   logic       pop = 1'b0;
   logic [7:0] pop_data;
   logic       pop_valid;
   logic       full;
   logic       empty;
   logic [4:0] count;
   logic       overflow;
   logic       underflow;
   logic       err_clr = 1'b0;
`ifdef RAM_FIFO_ALMOST_FLAGS_EN
   logic       almost_full;
   logic       almost_empty;
`endif
   logic       ram_wr_en;
   logic       ram_port_en_0;
   logic [3:0] ram_addr_0;
   logic [7:0] ram_data_in;
   logic       ram_port_en_1;
   logic [3:0] ram_addr_1;
   logic [7:0] ram_data_out_1;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   logic [7:0] q[$];
   int         m_wr = 0;
   int         m_rd = 0;
   bit         m_ovf = 0;
   bit         m_udf = 0;
   bit         exp_valid = 0;
   logic [7:0] exp_data = '0;

   // Behavioural RAM: port-0 write, port-1 registered read
   logic [7:0] mem [16];

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_wr_en && ram_port_en_0) mem[ram_addr_0] <= ram_data_in;
      if (ram_port_en_1) ram_data_out_1 <= mem[ram_addr_1];
   end

   ram_fifo_ctrl dut (
      .clk            (clk),
      .rst            (rst),
      .flush          (flush),
      .push           (push),
      .push_data      (push_data),
      .pop            (pop),
      .pop_data       (pop_data),
      .pop_valid      (pop_valid),
      .full           (full),
      .empty          (empty),
      .count          (count),
      .overflow       (overflow),
      .underflow      (underflow),
      .err_clr        (err_clr),
`ifdef RAM_FIFO_ALMOST_FLAGS_EN
      .almost_full    (almost_full),
      .almost_empty   (almost_empty),
`endif
      .ram_wr_en      (ram_wr_en),
      .ram_port_en_0  (ram_port_en_0),
      .ram_addr_0     (ram_addr_0),
      .ram_data_in    (ram_data_in),
      .ram_port_en_1  (ram_port_en_1),
      .ram_addr_1     (ram_addr_1),
      .ram_data_out_1 (ram_data_out_1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_wr = 0;
      m_rd = 0;
      m_ovf = 0;
      m_udf = 0;
      exp_valid = 0;
   endtask

   // One clock cycle: drive, check against model before the edge, then advance model
   task automatic cycle(input bit p, input logic [7:0] d, input bit o, input bit f, input bit ec);
      int cnt;
      bit pacc, oacc, oset, uset;
      push = p; push_data = d; pop = o; flush = f; err_clr = ec;
      #3;
      cnt  = q.size();
      pacc = p && cnt < 16 && !f;
      oacc = o && cnt > 0 && !f;
      oset = p && cnt == 16 && !f;
      uset = o && cnt == 0 && !f;
      chk("count", count, cnt);
      chk("full", full, cnt == 16);
      chk("empty", empty, cnt == 0);
      chk("overflow", overflow, m_ovf);
      chk("underflow", underflow, m_udf);
      chk("pop_valid", pop_valid, exp_valid);
      if (exp_valid) chk("pop_data", pop_data, exp_data);
      chk("ram_wr_en", ram_wr_en, pacc);
      chk("ram_port_en_0", ram_port_en_0, pacc);
      if (pacc) begin
         chk("ram_addr_0", ram_addr_0, m_wr);
         chk("ram_data_in", ram_data_in, d);
      end
      chk("ram_port_en_1", ram_port_en_1, oacc);
      if (oacc) chk("ram_addr_1", ram_addr_1, m_rd);
`ifdef RAM_FIFO_ALMOST_FLAGS_EN
      chk("almost_full", almost_full, cnt >= 14);
      chk("almost_empty", almost_empty, cnt <= 2);
`endif
      @(posedge clk);
      exp_valid = oacc;
      if (oacc) begin
         exp_data = q.pop_front();
         m_rd = (m_rd + 1) % 16;
      end
      if (pacc) begin
         q.push_back(d);
         m_wr = (m_wr + 1) % 16;
      end
      if (f) begin
         q.delete();
         m_wr = 0;
         m_rd = 0;
         exp_valid = 0;
      end
      m_ovf = oset ? 1'b1 : (ec ? 1'b0 : m_ovf);
      m_udf = uset ? 1'b1 : (ec ? 1'b0 : m_udf);
      #1;
   endtask

   initial begin
      // Reset held for two edges with requests driven: nothing reaches the RAM
      push = 1'b1; pop = 1'b1; push_data = 8'hEE;
      model_reset();
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         chk("rst_wr_en", ram_wr_en, 0);
         chk("rst_port_en_0", ram_port_en_0, 0);
         chk("rst_port_en_1", ram_port_en_1, 0);
         chk("rst_count", count, 0);
         chk("rst_empty", empty, 1);
         chk("rst_full", full, 0);
         chk("rst_pop_valid", pop_valid, 0);
      end
      push = 1'b0; pop = 1'b0;
      rst = 1'b0;

      // Fill 1..16, then a rejected 17th push
      for (int i = 1; i <= 16; i++) cycle(1, 8'(i), 0, 0, 0);
      cycle(1, 8'h99, 0, 0, 0);
      // Drain 16, then a rejected 17th pop, then clear errors
      for (int i = 0; i < 16; i++) cycle(0, 8'h00, 1, 0, 0);
      cycle(0, 8'h00, 1, 0, 0);
      cycle(0, 8'h00, 0, 0, 1);
      cycle(0, 8'h00, 0, 0, 0);

      // Push+pop at empty, fill to full, push+pop at full, drain
      cycle(1, 8'hAA, 1, 0, 0);
      for (int i = 0; i < 15; i++) cycle(1, 8'(8'hB0 + i), 0, 0, 0);
      cycle(1, 8'hCC, 1, 0, 0);
      cycle(0, 8'h00, 0, 0, 1);
      for (int i = 0; i < 15; i++) cycle(0, 8'h00, 1, 0, 0);
      cycle(0, 8'h00, 0, 0, 0);

      // Wrap-around: pointers cross 15 -> 0 during these bursts
      for (int i = 0; i < 10; i++) cycle(1, 8'(8'h10 + i), 0, 0, 0);
      for (int i = 0; i < 10; i++) cycle(0, 8'h00, 1, 0, 0);
      for (int i = 0; i < 10; i++) cycle(1, 8'(8'h20 + i), 0, 0, 0);
      for (int i = 0; i < 10; i++) cycle(0, 8'h00, 1, 0, 0);
      cycle(0, 8'h00, 0, 0, 0);

      // Flush with requests present: ignored, no error flags, state cleared
      for (int i = 0; i < 3; i++) cycle(1, 8'(8'h40 + i), 0, 0, 0);
      cycle(0, 8'h00, 1, 0, 0);
      cycle(1, 8'h77, 1, 1, 0);
      cycle(0, 8'h00, 1, 1, 0);
      cycle(1, 8'h78, 0, 0, 0);
      cycle(0, 8'h00, 1, 0, 0);
      cycle(0, 8'h00, 0, 0, 0);

      // Random traffic, including error set/clear collisions and rare flushes
      for (int i = 0; i < 400; i++)
         cycle($urandom_range(0, 99) < 55, 8'($urandom), $urandom_range(0, 99) < 50,
               $urandom_range(0, 31) == 0, $urandom_range(0, 7) == 0);
      for (int i = 0; i < 17; i++) cycle(0, 8'h00, 1, 0, 0);
      cycle(0, 8'h00, 0, 0, 1);

      // Asynchronous reset between edges while a read result is pending
      cycle(1, 8'h66, 0, 0, 0);
      cycle(0, 8'h00, 1, 0, 0);
      push = 1'b1; pop = 1'b0; push_data = 8'h12;
      #1 rst = 1'b1;
      #1;
      chk("async_pop_valid", pop_valid, 0);
      chk("async_count", count, 0);
      chk("async_empty", empty, 1);
      chk("async_wr_en", ram_wr_en, 0);
      model_reset();
      @(posedge clk);
      #1 rst = 1'b0;
      push = 1'b0;
      cycle(1, 8'h55, 0, 0, 0);
      cycle(0, 8'h00, 1, 0, 0);
      cycle(0, 8'h00, 0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
